// File: rtl/axi4_burst_slave_mem_pkg.sv
// axi4_burst_slave_pkg: shared AXI4 encodings, FSM state types and command checks
package axi4_burst_slave_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_4B = 3'd2;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst);
    return size != SIZE_4B || (burst != BURST_FIXED && burst != BURST_INCR);
  endfunction
endpackage

// File: rtl/axi4_burst_slave_mem_if.sv
// axi4_burst_slave_mem_if: AXI4 write/read channel bundle with master and slave views
interface axi4_burst_slave_mem_if #(
  parameter int C_S_AXI_ID_WIDTH = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
);
  logic [C_S_AXI_ID_WIDTH-1:0] awid, bid, arid, rid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata, rdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_burst_slave_mem_ram.sv
// axi4_burst_slave_ram: word-addressed RAM, byte-enabled write port, combinational read port
module axi4_burst_slave_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wstrb_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [2**AW];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we_i && wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axi4_burst_slave_mem.sv
// axi4_burst_slave_mem: AXI4 INCR/FIXED burst slave over a register memory, one
// outstanding write and one outstanding read on independent FSMs.
module axi4_burst_slave_mem
  import axi4_burst_slave_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input logic ACLK,
  input logic ARESET,
  axi4_burst_slave_mem_if.slave s_axi
);
  localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
  logic alive_q;
  wr_state_t ws_q, ws_d;
  logic [C_S_AXI_ID_WIDTH-1:0] wid_q, wid_d, rid_q, rid_d;
  logic [WA-1:0] wad_q, wad_d, rad_q, rad_d, rnext, raddr;
  logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d, rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic wfix_q, wfix_d, werr_q, werr_d, rfix_q, rfix_d, rerr_q, rerr_d;
  rd_state_t rs_q, rs_d;
  logic [31:0] rdata_q, rdata_d, ram_rd;
  logic we;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};
  axi4_burst_slave_ram #(.AW(WA)) u_ram (
    .clk(ACLK), .we_i(we), .waddr_i(wad_q), .wstrb_i(s_axi.wstrb), .wdata_i(s_axi.wdata),
    .raddr_i(raddr), .rdata_o(ram_rd)
  );
  always_comb begin
    ws_d = ws_q;
    wid_d = wid_q;
    wad_d = wad_q;
    wlen_d = wlen_q;
    wcnt_d = wcnt_q;
    wfix_d = wfix_q;
    werr_d = werr_q;
    we = 1'b0;
    case (ws_q)
      W_IDLE: if (alive_q && s_axi.awvalid) begin
        wid_d = s_axi.awid;
        wad_d = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        wlen_d = s_axi.awlen;
        wfix_d = s_axi.awburst == BURST_FIXED;
        werr_d = bad_cmd(s_axi.awsize, s_axi.awburst);
        wcnt_d = '0;
        ws_d = W_DATA;
      end
      W_DATA: if (s_axi.wvalid) begin
        we = !werr_q;
        wcnt_d = wcnt_q + 8'd1;
        wad_d = wfix_q ? wad_q : wad_q + WA'(1);
        if (s_axi.wlast) begin
          werr_d = werr_q | (wcnt_q != wlen_q);
          ws_d = W_RESP;
        end else if (wcnt_q == wlen_q) werr_d = 1'b1;
      end
      W_RESP: if (s_axi.bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end
  // the RAM read port looks at the AR address when idle, else at the next beat's word
  assign rnext = rfix_q ? rad_q : rad_q + WA'(1);
  assign raddr = (rs_q == R_IDLE) ? s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2] : rnext;
  always_comb begin
    rs_d = rs_q;
    rid_d = rid_q;
    rad_d = rad_q;
    rlen_d = rlen_q;
    rcnt_d = rcnt_q;
    rfix_d = rfix_q;
    rerr_d = rerr_q;
    rdata_d = rdata_q;
    case (rs_q)
      R_IDLE: if (alive_q && s_axi.arvalid) begin
        rid_d = s_axi.arid;
        rad_d = raddr;
        rlen_d = s_axi.arlen;
        rfix_d = s_axi.arburst == BURST_FIXED;
        rerr_d = bad_cmd(s_axi.arsize, s_axi.arburst);
        rcnt_d = '0;
        rdata_d = rerr_d ? '0 : ram_rd;
        rs_d = R_DATA;
      end
      R_DATA: if (s_axi.rready) begin
        if (rcnt_q == rlen_q) rs_d = R_IDLE;
        else begin
          rcnt_d = rcnt_q + 8'd1;
          rad_d = rnext;
          rdata_d = rerr_q ? '0 : ram_rd;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      alive_q <= 1'b0;
      ws_q <= W_IDLE;
      wid_q <= '0;
      wad_q <= '0;
      wlen_q <= '0;
      wcnt_q <= '0;
      wfix_q <= 1'b0;
      werr_q <= 1'b0;
      rs_q <= R_IDLE;
      rid_q <= '0;
      rad_q <= '0;
      rlen_q <= '0;
      rcnt_q <= '0;
      rfix_q <= 1'b0;
      rerr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      alive_q <= 1'b1;
      ws_q <= ws_d;
      wid_q <= wid_d;
      wad_q <= wad_d;
      wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;
      wfix_q <= wfix_d;
      werr_q <= werr_d;
      rs_q <= rs_d;
      rid_q <= rid_d;
      rad_q <= rad_d;
      rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;
      rfix_q <= rfix_d;
      rerr_q <= rerr_d;
      rdata_q <= rdata_d;
    end
  assign s_axi.awready = alive_q && ws_q == W_IDLE;
  assign s_axi.wready = ws_q == W_DATA;
  assign s_axi.bvalid = ws_q == W_RESP;
  assign s_axi.bid = wid_q;
  assign s_axi.bresp = (s_axi.bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.arready = alive_q && rs_q == R_IDLE;
  assign s_axi.rvalid = rs_q == R_DATA;
  assign s_axi.rid = rid_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = (s_axi.rvalid && rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rlast = s_axi.rvalid && rcnt_q == rlen_q;
endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// tb_axi4_burst_slave_mem: directed and randomized bursts checked against a word-array memory model
module tb_axi4_burst_slave_mem;
  import axi4_burst_slave_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  axi4_burst_slave_mem_if ax ();
  axi4_burst_slave_mem dut (.ACLK(clk), .ARESET(rst), .s_axi(ax));

  int tests = 0, fails = 0;
  logic [31:0] mdl [256];
  logic [31:0] wd [256];
  logic [3:0] wsb [256];
  logic [31:0] gd [256];
  logic [1:0] gr [256];
  logic gl [256];
  int gn, unstable;
  logic [1:0] bresp_c;
  logic bid_c, rid_c, lat_ok;

  function automatic logic [1:0] model_write(input logic [9:0] a, input logic [7:0] len,
                                             input logic [1:0] bst, input logic [2:0] sz, input int nb);
    logic bad;
    logic [7:0] w;
    bad = sz != SIZE_4B || bst > BURST_INCR;
    for (int i = 0; i < nb && i <= int'(len); i++)
      if (!bad) begin
        w = (bst == BURST_FIXED) ? a[9:2] : a[9:2] + 8'(i);
        for (int b = 0; b < 4; b++) if (wsb[i][b]) mdl[w][8*b +: 8] = wd[i][8*b +: 8];
      end
    return (bad || nb != int'(len) + 1) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [9:0] a, input logic [1:0] bst, input logic [2:0] sz, input int i);
    logic [7:0] w;
    w = (bst == BURST_FIXED) ? a[9:2] : a[9:2] + 8'(i);
    return (sz != SIZE_4B || bst > BURST_INCR) ? 32'h0 : mdl[w];
  endfunction

  function automatic logic [1:0] exp_resp(input logic [1:0] bst, input logic [2:0] sz);
    return (sz != SIZE_4B || bst > BURST_INCR) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic idle_bus();
    ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0; ax.awburst = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0; ax.arburst = '0; ax.arvalid = 1'b0;
    ax.rready = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] len, input logic [1:0] bst,
                          input logic [2:0] sz, input int nb, input logic id);
    int t;
    @(negedge clk);
    ax.awid = id; ax.awaddr = a; ax.awlen = len; ax.awsize = sz; ax.awburst = bst; ax.awvalid = 1'b1;
    t = 0;
    while (!ax.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tests++; fails++; $display("FAIL aw_timeout awready stuck at 0, want 1"); end
    @(negedge clk);
    ax.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ax.wvalid = 1'b1; ax.wdata = wd[i]; ax.wstrb = wsb[i]; ax.wlast = (i == nb - 1);
      t = 0;
      while (!ax.wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin tests++; fails++; $display("FAIL w_timeout beat %0d wready stuck at 0, want 1", i); end
      @(negedge clk);
    end
    ax.wvalid = 1'b0; ax.wlast = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ax.bready = 1'b1;
    t = 0;
    while (!ax.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tests++; fails++; $display("FAIL b_timeout bvalid stuck at 0, want 1"); end
    bresp_c = ax.bresp; bid_c = ax.bid;
    @(negedge clk);
    ax.bready = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input logic [7:0] len, input logic [1:0] bst,
                         input logic [2:0] sz, input logic id, input int mode);
    int t;
    logic done, pstall, pl;
    logic [31:0] pd;
    logic [1:0] pr;
    @(negedge clk);
    ax.arid = id; ax.araddr = a; ax.arlen = len; ax.arsize = sz; ax.arburst = bst; ax.arvalid = 1'b1;
    t = 0;
    while (!ax.arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tests++; fails++; $display("FAIL ar_timeout arready stuck at 0, want 1"); end
    @(negedge clk);
    ax.arvalid = 1'b0;
    lat_ok = ax.rvalid;
    gn = 0; unstable = 0; pstall = 1'b0; done = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    for (t = 0; t < 3000 && !done; t++) begin
      ax.rready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 1) : 1'($urandom_range(0, 1));
      if (pstall && (ax.rdata !== pd || ax.rresp !== pr || ax.rlast !== pl || !ax.rvalid)) unstable++;
      pd = ax.rdata; pr = ax.rresp; pl = ax.rlast;
      pstall = ax.rvalid && !ax.rready;
      if (ax.rvalid && ax.rready) begin
        gd[gn] = ax.rdata; gr[gn] = ax.rresp; gl[gn] = ax.rlast; rid_c = ax.rid;
        gn++;
        done = ax.rlast || gn == 256;
      end
      @(negedge clk);
    end
    if (!done) begin tests++; fails++; $display("FAIL r_timeout got %0d beats, want %0d", gn, int'(len) + 1); end
    ax.rready = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    repeat (3) @(negedge clk);
    tests++;
    if ({ax.awready, ax.wready, ax.bvalid, ax.bresp, ax.bid, ax.arready, ax.rvalid, ax.rid, ax.rdata, ax.rresp, ax.rlast} !== '0) begin
      fails++; $display("FAIL reset_outputs got nonzero aw/w/b/ar/r outputs, want all 0");
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({ax.awready, ax.arready} !== 2'b00) begin fails++; $display("FAIL reset_release got %b, want 00", {ax.awready, ax.arready}); end
    @(negedge clk);
    tests++;
    if ({ax.awready, ax.arready} !== 2'b11) begin fails++; $display("FAIL ready_after_reset got %b, want 11", {ax.awready, ax.arready}); end
  endtask

  task automatic test_fill();
    logic [1:0] er;
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; wsb[i] = 4'hF; end
    er = model_write(10'h000, 8'd255, BURST_INCR, SIZE_4B, 256);
    do_write(10'h000, 8'd255, BURST_INCR, SIZE_4B, 256, 1'b0);
    tests++;
    if (bresp_c !== er) begin fails++; $display("FAIL fill_bresp got %b want %b", bresp_c, er); end
    do_read(10'h000, 8'd255, BURST_INCR, SIZE_4B, 1'b0, 0);
    tests++;
    if (gn !== 256) begin fails++; $display("FAIL fill_beats got %0d want 256", gn); end
    for (int i = 0; i < gn; i++) begin
      tests++;
      if (gd[i] !== exp_rd(10'h000, BURST_INCR, SIZE_4B, i) || gr[i] !== RESP_OKAY || gl[i] !== (i == 255)) begin
        fails++; $display("FAIL fill_beat %0d got %h/%b/%b want %h/00/%b", i, gd[i], gr[i], gl[i], exp_rd(10'h000, BURST_INCR, SIZE_4B, i), i == 255);
      end
    end
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; wsb[0] = 4'hF;
    void'(model_write(10'h010, 8'd0, BURST_INCR, SIZE_4B, 1));
    do_write(10'h010, 8'd0, BURST_INCR, SIZE_4B, 1, 1'b1);
    tests++;
    if ({bresp_c, bid_c} !== {RESP_OKAY, 1'b1}) begin fails++; $display("FAIL single_b got resp %b id %b want 00 1", bresp_c, bid_c); end
    do_read(10'h010, 8'd0, BURST_INCR, SIZE_4B, 1'b1, 0);
    tests++;
    if (lat_ok !== 1'b1) begin fails++; $display("FAIL single_rvalid_latency got %b want 1", lat_ok); end
    tests++;
    if (gn !== 1 || gd[0] !== 32'hDEADBEEF || gl[0] !== 1'b1 || gr[0] !== RESP_OKAY || rid_c !== 1'b1) begin
      fails++; $display("FAIL single_r got n=%0d %h last %b resp %b id %b want n=1 deadbeef 1 00 1", gn, gd[0], gl[0], gr[0], rid_c);
    end
  endtask

  task automatic test_wrap_stall();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wsb[i] = 4'hF; end
    void'(model_write(10'h3F8, 8'd3, BURST_INCR, SIZE_4B, 4));
    do_write(10'h3F8, 8'd3, BURST_INCR, SIZE_4B, 4, 1'b0);
    tests++;
    if (bresp_c !== RESP_OKAY) begin fails++; $display("FAIL wrap_bresp got %b want 00", bresp_c); end
    do_read(10'h3F8, 8'd3, BURST_INCR, SIZE_4B, 1'b0, 1);
    tests++;
    if (unstable !== 0) begin fails++; $display("FAIL wrap_stall_stable got %0d changes want 0", unstable); end
    tests++;
    if (gn !== 4) begin fails++; $display("FAIL wrap_beats got %0d want 4", gn); end
    for (int i = 0; i < gn; i++) begin
      tests++;
      if (gd[i] !== 32'(i + 1) || gl[i] !== (i == 3)) begin
        fails++; $display("FAIL wrap_beat %0d got %h last %b want %h last %b", i, gd[i], gl[i], i + 1, i == 3);
      end
    end
    do_read(10'h000, 8'd0, BURST_INCR, SIZE_4B, 1'b0, 0);
    tests++;
    if (gd[0] !== 32'h3) begin fails++; $display("FAIL wrap_word0 got %h want 00000003", gd[0]); end
  endtask

  task automatic test_strobe();
    wd[0] = 32'hFFFFFFFF; wsb[0] = 4'hF;
    void'(model_write(10'h020, 8'd0, BURST_INCR, SIZE_4B, 1));
    do_write(10'h020, 8'd0, BURST_INCR, SIZE_4B, 1, 1'b0);
    wd[0] = 32'h12345678; wsb[0] = 4'b0101;
    void'(model_write(10'h020, 8'd0, BURST_INCR, SIZE_4B, 1));
    do_write(10'h020, 8'd0, BURST_INCR, SIZE_4B, 1, 1'b0);
    do_read(10'h020, 8'd0, BURST_INCR, SIZE_4B, 1'b0, 2);
    tests++;
    if (gd[0] !== 32'hFF34FF78) begin fails++; $display("FAIL strobe_data got %h want ff34ff78", gd[0]); end
  endtask

  task automatic test_fixed_and_wrap();
    logic [1:0] er;
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wsb[0] = 4'hF; wsb[1] = 4'hF; wsb[2] = 4'hF;
    void'(model_write(10'h040, 8'd2, BURST_FIXED, SIZE_4B, 3));
    do_write(10'h040, 8'd2, BURST_FIXED, SIZE_4B, 3, 1'b0);
    do_read(10'h040, 8'd1, BURST_INCR, SIZE_4B, 1'b0, 0);
    tests++;
    if (gd[0] !== 32'hC || gd[1] !== exp_rd(10'h044, BURST_INCR, SIZE_4B, 0)) begin
      fails++; $display("FAIL fixed_data got %h %h want 0000000c %h", gd[0], gd[1], exp_rd(10'h044, BURST_INCR, SIZE_4B, 0));
    end
    do_read(10'h040, 8'd2, BURST_FIXED, SIZE_4B, 1'b0, 0);
    tests++;
    if (gn !== 3 || gd[0] !== 32'hC || gd[1] !== 32'hC || gd[2] !== 32'hC || gl[2] !== 1'b1) begin
      fails++; $display("FAIL fixed_read got n=%0d %h %h %h want n=3 c c c", gn, gd[0], gd[1], gd[2]);
    end
    wd[0] = 32'h55AA55AA; wd[1] = 32'hAA55AA55; wsb[0] = 4'hF; wsb[1] = 4'hF;
    er = model_write(10'h080, 8'd1, BURST_WRAP, SIZE_4B, 2);
    do_write(10'h080, 8'd1, BURST_WRAP, SIZE_4B, 2, 1'b0);
    tests++;
    if (bresp_c !== er) begin fails++; $display("FAIL wrapburst_bresp got %b want %b", bresp_c, er); end
    do_read(10'h080, 8'd1, BURST_INCR, SIZE_4B, 1'b0, 0);
    tests++;
    if (gd[0] !== exp_rd(10'h080, BURST_INCR, SIZE_4B, 0) || gd[1] !== exp_rd(10'h080, BURST_INCR, SIZE_4B, 1)) begin
      fails++; $display("FAIL wrapburst_unchanged got %h %h want %h %h", gd[0], gd[1], exp_rd(10'h080, BURST_INCR, SIZE_4B, 0), exp_rd(10'h080, BURST_INCR, SIZE_4B, 1));
    end
    do_read(10'h080, 8'd1, BURST_WRAP, SIZE_4B, 1'b0, 0);
    tests++;
    if (gn !== 2 || gd[0] !== 32'h0 || gr[0] !== RESP_SLVERR || gr[1] !== RESP_SLVERR || gl[1] !== 1'b1) begin
      fails++; $display("FAIL wrapburst_read got n=%0d %h resp %b want n=2 0 10", gn, gd[0], gr[0]);
    end
  endtask

  task automatic test_early_last();
    logic [1:0] er;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; wsb[i] = 4'hF; end
    er = model_write(10'h100, 8'd3, BURST_INCR, SIZE_4B, 2);
    do_write(10'h100, 8'd3, BURST_INCR, SIZE_4B, 2, 1'b1);
    tests++;
    if (bresp_c !== RESP_SLVERR || er !== RESP_SLVERR) begin fails++; $display("FAIL early_bresp got %b want 10", bresp_c); end
    tests++;
    if (ax.awready !== 1'b1) begin fails++; $display("FAIL early_idle awready got %b want 1", ax.awready); end
    do_read(10'h100, 8'd3, BURST_INCR, SIZE_4B, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gd[i] !== exp_rd(10'h100, BURST_INCR, SIZE_4B, i)) begin
        fails++; $display("FAIL early_beat %0d got %h want %h", i, gd[i], exp_rd(10'h100, BURST_INCR, SIZE_4B, i));
      end
    end
  endtask

  task automatic test_reset_midread();
    int t;
    @(negedge clk);
    ax.arid = 1'b0; ax.araddr = 10'h200; ax.arlen = 8'd3; ax.arsize = SIZE_4B; ax.arburst = BURST_INCR; ax.arvalid = 1'b1;
    t = 0;
    while (!ax.arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    ax.arvalid = 1'b0; ax.rready = 1'b1;
    @(negedge clk);
    tests++;
    if (ax.rvalid !== 1'b1 || ax.rdata !== exp_rd(10'h200, BURST_INCR, SIZE_4B, 1)) begin
      fails++; $display("FAIL midread_beat2 got %b %h want 1 %h", ax.rvalid, ax.rdata, exp_rd(10'h200, BURST_INCR, SIZE_4B, 1));
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ax.rvalid, ax.arready, ax.rlast, ax.rdata} !== '0) begin fails++; $display("FAIL midread_abort got rvalid %b arready %b want 0 0", ax.rvalid, ax.arready); end
    @(negedge clk);
    rst = 1'b0; ax.rready = 1'b0;
    @(negedge clk);
    tests++;
    if ({ax.arready, ax.rvalid} !== 2'b10) begin fails++; $display("FAIL midread_release got %b want 10", {ax.arready, ax.rvalid}); end
    repeat (3) @(negedge clk);
    tests++;
    if (ax.rvalid !== 1'b0) begin fails++; $display("FAIL midread_no_rvalid got %b want 0", ax.rvalid); end
    do_read(10'h200, 8'd3, BURST_INCR, SIZE_4B, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gd[i] !== exp_rd(10'h200, BURST_INCR, SIZE_4B, i) || gl[i] !== (i == 3)) begin
        fails++; $display("FAIL midread_after beat %0d got %h want %h", i, gd[i], exp_rd(10'h200, BURST_INCR, SIZE_4B, i));
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] a;
    logic [7:0] len;
    logic [1:0] bst, er;
    logic [2:0] sz;
    logic id;
    int nb, r;
    for (int n = 0; n < 40; n++) begin
      a = 10'($urandom);
      len = 8'($urandom_range(0, 12));
      r = $urandom_range(0, 9);
      bst = (r < 6) ? BURST_INCR : (r < 9) ? BURST_FIXED : BURST_WRAP;
      sz = ($urandom_range(0, 9) == 0) ? 3'd1 : SIZE_4B;
      nb = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(1, int'(len)) : int'(len) + 1;
      id = 1'($urandom);
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; wsb[i] = 4'($urandom); end
      er = model_write(a, len, bst, sz, nb);
      do_write(a, len, bst, sz, nb, id);
      tests++;
      if (bresp_c !== er || bid_c !== id) begin fails++; $display("FAIL rand_b %0d got %b/%b want %b/%b", n, bresp_c, bid_c, er, id); end
      if ($urandom_range(0, 1) == 1) begin
        bst = ($urandom_range(0, 5) == 0) ? BURST_WRAP : BURST_INCR;
        sz = ($urandom_range(0, 9) == 0) ? 3'd0 : SIZE_4B;
      end
      do_read(a, len, bst, sz, ~id, $urandom_range(0, 2));
      tests++;
      if (gn !== int'(len) + 1 || unstable !== 0 || rid_c !== ~id) begin
        fails++; $display("FAIL rand_r %0d got n=%0d unstable=%0d id=%b want n=%0d 0 %b", n, gn, unstable, rid_c, int'(len) + 1, ~id);
      end
      for (int i = 0; i < gn; i++) begin
        tests++;
        if (gd[i] !== exp_rd(a, bst, sz, i) || gr[i] !== exp_resp(bst, sz) || gl[i] !== (i == int'(len))) begin
          fails++; $display("FAIL rand_beat %0d.%0d got %h/%b/%b want %h/%b/%b", n, i, gd[i], gr[i], gl[i], exp_rd(a, bst, sz, i), exp_resp(bst, sz), i == int'(len));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_wrap_stall();
    test_strobe();
    test_fixed_and_wrap();
    test_early_last();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_burst_slave_mem.md
Name: axi4_burst_slave_mem

Overview:
- AXI4 (full) slave responder backed by a word-addressed register memory; the counterpart of the custom AXI4 master IP (M00_AXI).
- Sits in the block design on the master's M00_AXI port and replaces the VIP slave memory in system-level and FPGA runs.
- Supports INCR and FIXED bursts with one outstanding write and one outstanding read; the two channels are independent.
- Reports the master's protocol misuse through SLVERR so that the master's ERROR output can be exercised.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 10, byte address width; memory depth is 2^(C_S_AXI_ADDR_WIDTH-2) words.

Ports:
- ACLK  in  1  clock for all logic.
- ARESET  in  1  asynchronous active-high reset.
- S_AXI_AWID  in  ID  write ID.
- S_AXI_AWADDR  in  ADDR  write start byte address.
- S_AXI_AWLEN  in  8  beats-1.
- S_AXI_AWSIZE  in  3  beat size.
- S_AXI_AWBURST  in  2  burst type.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WLAST  in  1  last write beat.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- S_AXI_BID  out  ID / S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARID  in  ID / S_AXI_ARADDR  in  ADDR / S_AXI_ARLEN  in  8 / S_AXI_ARSIZE  in  3 / S_AXI_ARBURST  in  2  read address.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AR handshake.
- S_AXI_RID  out  ID / S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RLAST  out  1  read data.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  R handshake.
- No other AXI signals are present. LOCK, CACHE, PROT, QOS and USER are not ported.

Behaviour:
- Reset: all outputs are 0 and both FSMs are in IDLE. AWREADY and ARREADY rise the first cycle after ARESET falls. Memory contents are not reset.
- Reset asserted mid-burst: the burst is aborted immediately, outputs go to 0, and no BVALID/RVALID is produced afterwards for the aborted burst. Memory writes already committed are retained.
- Write FSM, W_IDLE: AWREADY=1. On AW handshake, latch ID, word address (AWADDR[ADDR-1:2]), LEN and burst. Set err = (AWSIZE!=2) or (AWBURST not in {FIXED=00, INCR=01}). Go to W_DATA.
- Write FSM, W_DATA: WREADY=1.
  - Each W handshake writes the bytes selected by WSTRB at the current word, unless err is set or the beat count exceeds LEN.
  - INCR advances the word address by +1, modulo depth, so addresses wrap at the top of memory. FIXED holds the address.
  - On a WLAST beat, err |= (beatcnt != LEN); then go to W_RESP.
  - A beat at count LEN without WLAST sets err; data is consumed and dropped until WLAST.
- Write FSM, W_RESP: BVALID=1, BID=latched ID, BRESP=err?SLVERR(10):OKAY(00). On BREADY, go to W_IDLE.
- AWREADY is 0 outside W_IDLE. Minimum AW-to-AW period is LEN+3 cycles.
- Read FSM, R_IDLE: ARREADY=1. On AR handshake, latch ID, address, LEN and err, using the same rules as write. Load the RDATA register from mem[addr], or 0 if err. Go to R_DATA, so RVALID is high the cycle after the AR handshake.
- Read FSM, R_DATA: RVALID=1, RID=latched, RRESP per err, RLAST=(beatcnt==LEN).
  - RDATA, RRESP and RLAST are held stable while RREADY=0.
  - On handshake with RLAST, go to R_IDLE. Otherwise advance the address per burst type and load the next word.
- Same-cycle write and RDATA load at the same word: RDATA takes the pre-write value. Writes are visible from the next cycle.
- LEN=0 bursts are legal. LEN=255 is the maximum; beatcnt is 8 bits.

Decomposition:
- Package axi4_burst_slave_pkg holds:
  - burst encodings (FIXED, INCR, WRAP);
  - response encodings (OKAY, SLVERR);
  - SIZE_4B=3'd2;
  - wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- One sub-module, axi4_burst_slave_ram: one write port with a 4-bit byte enable and one combinational read port, word-addressed, depth parameterised.

Test Plan:
- Single write then read: AW addr=0x010, LEN=0, WDATA=0xDEADBEEF, WSTRB=F. Expect BRESP=OKAY. Then AR 0x010 returns RDATA=0xDEADBEEF, RLAST=1, RRESP=OKAY.
- INCR LEN=3 at 0x3F8: write 1,2,3,4, then read back with RREADY toggling every other cycle. Expect 1,2,3,4 at words 0xFE, 0xFF, 0x00, 0x01 (wrap-around), data stable during stalls, and RLAST only on beat 4.
- Partial strobes: write 0xFFFFFFFF then 0x12345678 with WSTRB=0101 to 0x020. Expect a read of 0xFF34FF78.
- FIXED LEN=2 writes 0xA, 0xB, 0xC to 0x040. Expect a read of 0x0000000C. WRAP burst (AWBURST=10): expect SLVERR and memory unchanged.
- Early WLAST on beat 2 of LEN=3: expect BRESP=SLVERR, beats 1-2 written, and the FSM back in W_IDLE after BREADY.
- ARESET pulse during beat 2 of a 4-beat read: expect RVALID=0 immediately, ARREADY=1 the cycle after release, and a subsequent read correct. System test with the custom master: INIT pulse, then TXN_DONE=1 and ERROR=0.
